fetch_issue: RTL and testbench
==============================

# fetch_issue

Producer side of the IF→ID instruction latch. Owns the fetch PC, issues single-outstanding requests to instruction memory, and presents each returned instruction with its PC and PC+4 to the downstream latch. Presentation is held under STALL, with a one-entry skid buffer. Redirects from the branch/exception logic squash wrong-path fetches and restart at the alternate PC.

## Interface
- RESET_PC, 32'hBFC00000: PC fetched first after reset.
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low; clears all state immediately.
- STALL  in  1  downstream latch frozen; the presented instruction is not consumed this cycle.
- Request_Alt_PC  in  1  redirect strobe; highest priority.
- Alt_PC  in  32  redirect target, sampled when Request_Alt_PC=1.
- Instr_req_2IM  out  1  memory request; memory accepts every asserted cycle.
- Instr_addr_2IM  out  32  request address (= PC).
- Instr1_fIM  in  32  returned instruction word.
- Instr_rvalid_fIM  in  1  response valid; ≥1 cycle after request, exactly one per request.
- Instr1_IF  out  32  presented instruction.
- Instr_PC_IF  out  32  address of presented instruction.
- Instr_PC_Plus4_IF  out  32  Instr_PC_IF+4.
- Instr_Valid_IF  out  1  presentation slot holds a valid instruction.

## Operation
- Registers: PC[31:0], state, slot (instr/PC/PC+4/valid = outputs), skid (instr/PC/valid).
- Consume: cycle with Instr_Valid_IF=1 and STALL=0; slot is free if !valid or consumed.
- States:
  - ISSUE: Instr_req_2IM=1, addr=PC. Without a redirect → WAIT. With a redirect → PC<=Alt_PC, → FLUSH (the issued request's response is dropped).
  - WAIT: Instr_req_2IM=0. On rvalid with a free slot: slot<=(data, PC, PC+4, 1), PC<=PC+4, → ISSUE. On rvalid with the slot not free: skid<=(data, PC, 1), PC<=PC+4, → HOLD. No rvalid: stay.
  - HOLD: no requests. When the slot is consumed: slot<=skid, skid.valid<=0, → ISSUE.
  - FLUSH: wait for rvalid, discard the data, → ISSUE.
- Redirect (any state, overrides the rules above):
  - PC<=Alt_PC; slot.valid<=0; skid.valid<=0.
  - In WAIT: with rvalid in the same cycle → ISSUE, else → FLUSH.
  - In FLUSH: stay in FLUSH unless rvalid arrives the same cycle (→ ISSUE).
  - In HOLD: → ISSUE.
- When the slot is consumed and no new data arrives, slot.valid<=0. Other slot fields keep their values.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 0. PC bits [1:0] pass through unchanged; no alignment check.
- Exactly one request outstanding; none is issued while the slot and skid are both full.

## Timing
- Reset (asynchronous, level): PC=RESET_PC, state=ISSUE, all outputs 0, Instr_Valid_IF=0, skid.valid=0.
  - The first Instr_req_2IM occurs in the first cycle after RESET rises.
  - Reset mid-WAIT abandons the outstanding request. The memory side must also be reset.
- Outputs are registered; Instr_req_2IM and Instr_addr_2IM are decoded from state and PC only.
- With 1-cycle memory (req at n, rvalid at n+1):
  - Instruction is valid at the outputs from edge n+2.
  - Next request is issued at n+2.
  - Throughput is 1 instruction / 2 cycles.
- With latency L, the instruction appears L+1 cycles after its request.
- A redirect at edge k takes effect immediately: Instr_Valid_IF=0 after edge k. The first Alt_PC instruction appears no earlier than:
  - k+3 from ISSUE, after the drop;
  - k+2 if the redirect coincides with rvalid in WAIT.
- STALL only gates consumption; it never blocks a response from landing (skid absorbs one).

## Test plan
- Reset: hold RESET=0 → outputs all 0, Valid=0, Instr_addr_2IM=32'hBFC00000, req=1 on the first cycle after release.
- Streaming: 1-cycle memory returning addr^32'h1234 → slot sequence PC BFC00000, BFC00004, BFC00008, each valid for one cycle, one per 2 cycles, Plus4 correct.
- Stall/skid: STALL=1 for 6 cycles after the first instruction → slot frozen at BFC00000, second instruction in skid, no third request. Release → BFC00004 is presented the next cycle, then requests resume at BFC00008.
- Redirect in WAIT: 3-cycle memory, Request_Alt_PC with Alt_PC=32'h00400020 one cycle after the request → Valid drops, stale response discarded, next request to 00400020, presented with Plus4=00400024.
- Redirect coincident with rvalid, and a redirect while in HOLD → data dropped, skid cleared, next request to Alt_PC with no FLUSH cycle.
- Wrap and reset-mid-op: Alt_PC=32'hFFFFFFFC → next fetch address 0. Assert RESET during WAIT → immediate clear, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_issue.sv
// IF-stage fetch/issue: owns the fetch PC, keeps one request outstanding to
// instruction memory and presents returned words to the IF/ID latch.
module fetch_issue #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    output logic        Instr_req_2IM,
    output logic [31:0] Instr_addr_2IM,
    input  logic [31:0] Instr1_fIM,
    input  logic        Instr_rvalid_fIM,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF,
    output logic        Instr_Valid_IF,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        skid_valid;

    logic        consume;
    logic        slot_free;
    logic [31:0] pc_plus4;

    // Handshake: the slot is offered while Instr_Valid_IF=1 and is taken on
    // any rising edge where STALL=0 (STALL acts as an inverted ready); memory
    // accepts every cycle with Instr_req_2IM=1 and answers with exactly one
    // Instr_rvalid_fIM pulse at least one cycle later.
    assign consume   = Instr_Valid_IF & ~STALL;
    assign slot_free = ~Instr_Valid_IF | consume;
    assign pc_plus4  = pc + 32'd4;

    assign Instr_req_2IM  = (state == ISSUE);
    assign Instr_addr_2IM = pc;
    assign fsm_state      = state;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state             <= ISSUE;
            pc                <= RESET_PC;
            Instr1_IF         <= 32'd0;
            Instr_PC_IF       <= 32'd0;
            Instr_PC_Plus4_IF <= 32'd0;
            Instr_Valid_IF    <= 1'b0;
            skid_instr        <= 32'd0;
            skid_pc           <= 32'd0;
            skid_valid        <= 1'b0;
        end else if (Request_Alt_PC) begin
            // Redirect squashes everything; any in-flight response is owed
            // to the old path and must be swallowed in FLUSH.
            pc             <= Alt_PC;
            Instr_Valid_IF <= 1'b0;
            skid_valid     <= 1'b0;
            case (state)
                ISSUE:   state <= FLUSH;
                WAIT:    state <= Instr_rvalid_fIM ? ISSUE : FLUSH;
                FLUSH:   state <= Instr_rvalid_fIM ? ISSUE : FLUSH;
                HOLD:    state <= ISSUE;
                default: state <= ISSUE;
            endcase
        end else begin
            if (consume) begin
                Instr_Valid_IF <= 1'b0;
            end
            case (state)
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (Instr_rvalid_fIM) begin
                        pc <= pc_plus4;
                        if (slot_free) begin
                            Instr1_IF         <= Instr1_fIM;
                            Instr_PC_IF       <= pc;
                            Instr_PC_Plus4_IF <= pc_plus4;
                            Instr_Valid_IF    <= 1'b1;
                            state             <= ISSUE;
                        end else begin
                            skid_instr <= Instr1_fIM;
                            skid_pc    <= pc;
                            skid_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Slot and skid both full: no new request until the slot drains.
                    if (consume) begin
                        Instr1_IF         <= skid_instr;
                        Instr_PC_IF       <= skid_pc;
                        Instr_PC_Plus4_IF <= skid_pc + 32'd4;
                        Instr_Valid_IF    <= skid_valid;
                        skid_valid        <= 1'b0;
                        state             <= ISSUE;
                    end
                end
                FLUSH: begin
                    if (Instr_rvalid_fIM) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_issue.sv
// Self-checking bench for fetch_issue: directed timing scenarios plus a
// randomized run scored against an in-order PC-stream reference.
module tb_fetch_issue;

    localparam logic [31:0] RST_PC = 32'hBFC00000;
    localparam logic [31:0] KEY    = 32'h00001234;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        Request_Alt_PC = 1'b0;
    logic [31:0] Alt_PC = 32'd0;
    logic        Instr_req_2IM;
    logic [31:0] Instr_addr_2IM;
    logic [31:0] Instr1_fIM = 32'd0;
    logic        Instr_rvalid_fIM = 1'b0;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Instr_Valid_IF;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_errors = 0;

    // memory model controls and state
    int          mem_lat = 1;
    bit          mem_rand_lat = 1'b0;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_req_cnt = 0;
    int          proto_viol = 0;
    logic        cap_req;
    logic [31:0] cap_addr;

    logic [31:0] exp_q[$];

    fetch_issue #(.RESET_PC(RST_PC)) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .Request_Alt_PC    (Request_Alt_PC),
        .Alt_PC            (Alt_PC),
        .Instr_req_2IM     (Instr_req_2IM),
        .Instr_addr_2IM    (Instr_addr_2IM),
        .Instr1_fIM        (Instr1_fIM),
        .Instr_rvalid_fIM  (Instr_rvalid_fIM),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
        .Instr_Valid_IF    (Instr_Valid_IF),
        .fsm_state         (fsm_state)
    );

    // clock / reset block
    always #5 CLK = ~CLK;

    // Instruction memory: accepts a request on each edge where req=1 and
    // returns addr^KEY after mem_lat cycles; flags overlapping requests.
    always @(posedge CLK) begin
        cap_req  = Instr_req_2IM & RESET;
        cap_addr = Instr_addr_2IM;
        #1;
        Instr_rvalid_fIM = 1'b0;
        if (!RESET) begin
            mem_busy = 1'b0;
        end else begin
            if (cap_req) begin
                if (mem_busy) begin
                    proto_viol++;
                    $display("FAIL single_outstanding: new req %h while %h pending", cap_addr, mem_addr);
                end
                mem_busy = 1'b1;
                mem_addr = cap_addr;
                mem_cnt  = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
                mem_req_cnt++;
            end
            if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    Instr_rvalid_fIM = 1'b1;
                    Instr1_fIM       = mem_addr ^ KEY;
                    mem_busy         = 1'b0;
                end
            end
        end
    end

    // driver: pulse reset and return on the negedge where it is released
    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0; STALL = 1'b0; Request_Alt_PC = 1'b0; Alt_PC = 32'd0;
        mem_lat = 1; mem_rand_lat = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        int base;
        RESET = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b0) begin n_errors++; $display("FAIL rst_valid got %b exp 0", Instr_Valid_IF); end
        n_checks++; if (Instr1_IF !== 32'd0) begin n_errors++; $display("FAIL rst_instr got %h exp 0", Instr1_IF); end
        n_checks++; if (Instr_PC_IF !== 32'd0) begin n_errors++; $display("FAIL rst_pc got %h exp 0", Instr_PC_IF); end
        n_checks++; if (Instr_PC_Plus4_IF !== 32'd0) begin n_errors++; $display("FAIL rst_plus4 got %h exp 0", Instr_PC_Plus4_IF); end
        n_checks++; if (Instr_addr_2IM !== RST_PC) begin n_errors++; $display("FAIL rst_addr got %h exp %h", Instr_addr_2IM, RST_PC); end
        base = mem_req_cnt;
        RESET = 1'b1;
        #1;
        n_checks++; if (Instr_req_2IM !== 1'b1) begin n_errors++; $display("FAIL rst_first_req got %b exp 1", Instr_req_2IM); end
        @(negedge CLK);
        n_checks++; if (mem_req_cnt - base !== 1) begin n_errors++; $display("FAIL rst_req_count got %0d exp 1", mem_req_cnt - base); end
        n_checks++; if (Instr_req_2IM !== 1'b0) begin n_errors++; $display("FAIL rst_wait_req got %b exp 0", Instr_req_2IM); end
    endtask

    task automatic test_streaming();
        logic [31:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(RST_PC + 32'(4 * i));
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            n_checks++; if (Instr_Valid_IF !== 1'b1) begin n_errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, Instr_Valid_IF); end
            n_checks++; if (Instr_PC_IF !== e) begin n_errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, Instr_PC_IF, e); end
            n_checks++; if (Instr1_IF !== (e ^ KEY)) begin n_errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, Instr1_IF, e ^ KEY); end
            n_checks++; if (Instr_PC_Plus4_IF !== e + 32'd4) begin n_errors++; $display("FAIL stream_plus4[%0d] got %h exp %h", i, Instr_PC_Plus4_IF, e + 32'd4); end
            n_checks++; if (Instr_req_2IM !== 1'b1 || Instr_addr_2IM !== e + 32'd4) begin n_errors++; $display("FAIL stream_next_req[%0d] got %b/%h exp 1/%h", i, Instr_req_2IM, Instr_addr_2IM, e + 32'd4); end
            @(negedge CLK);
            n_checks++; if (Instr_Valid_IF !== 1'b0) begin n_errors++; $display("FAIL stream_gap[%0d] got %b exp 0", i, Instr_Valid_IF); end
        end
    endtask

    task automatic test_stall_skid();
        int base;
        do_reset();
        base = mem_req_cnt;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== RST_PC) begin n_errors++; $display("FAIL stall_first got %b/%h exp 1/%h", Instr_Valid_IF, Instr_PC_IF, RST_PC); end
        STALL = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== RST_PC) begin n_errors++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/%h", i, Instr_Valid_IF, Instr_PC_IF, RST_PC); end
            n_checks++; if (Instr_req_2IM !== 1'b0) begin n_errors++; $display("FAIL stall_no_req[%0d] got %b exp 0", i, Instr_req_2IM); end
        end
        n_checks++; if (mem_req_cnt - base !== 2) begin n_errors++; $display("FAIL stall_req_count got %0d exp 2", mem_req_cnt - base); end
        STALL = 1'b0;
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== RST_PC + 32'd4) begin n_errors++; $display("FAIL skid_present got %b/%h exp 1/%h", Instr_Valid_IF, Instr_PC_IF, RST_PC + 32'd4); end
        n_checks++; if (Instr1_IF !== ((RST_PC + 32'd4) ^ KEY) || Instr_PC_Plus4_IF !== RST_PC + 32'd8) begin n_errors++; $display("FAIL skid_data got %h/%h exp %h/%h", Instr1_IF, Instr_PC_Plus4_IF, (RST_PC + 32'd4) ^ KEY, RST_PC + 32'd8); end
        n_checks++; if (Instr_req_2IM !== 1'b1 || Instr_addr_2IM !== RST_PC + 32'd8) begin n_errors++; $display("FAIL skid_resume got %b/%h exp 1/%h", Instr_req_2IM, Instr_addr_2IM, RST_PC + 32'd8); end
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b0 || mem_req_cnt - base !== 3) begin n_errors++; $display("FAIL skid_after got %b/%0d exp 0/3", Instr_Valid_IF, mem_req_cnt - base); end
    endtask

    task automatic test_redirect_wait();
        int base;
        int seen;
        do_reset();
        mem_lat = 3;
        base = mem_req_cnt;
        @(negedge CLK);
        Request_Alt_PC = 1'b1; Alt_PC = 32'h00400020;
        @(negedge CLK);
        Request_Alt_PC = 1'b0;
        n_checks++; if (Instr_Valid_IF !== 1'b0 || Instr_req_2IM !== 1'b0) begin n_errors++; $display("FAIL rw_flush got v=%b req=%b exp 0/0", Instr_Valid_IF, Instr_req_2IM); end
        n_checks++; if (Instr_addr_2IM !== 32'h00400020) begin n_errors++; $display("FAIL rw_pc got %h exp 00400020", Instr_addr_2IM); end
        seen = -1;
        for (int i = 0; i < 20 && seen < 0; i++) begin
            @(negedge CLK);
            if (Instr_Valid_IF === 1'b1) seen = i;
        end
        n_checks++;
        if (seen < 0) begin
            n_errors++; $display("FAIL rw_timeout got no valid within 20 cycles (state %0d) exp one", fsm_state);
        end else begin
            if (seen !== 5) begin n_errors++; $display("FAIL rw_latency got %0d exp 5", seen); end
            n_checks++; if (Instr_PC_IF !== 32'h00400020 || Instr_PC_Plus4_IF !== 32'h00400024) begin n_errors++; $display("FAIL rw_target got %h/%h exp 00400020/00400024", Instr_PC_IF, Instr_PC_Plus4_IF); end
            n_checks++; if (Instr1_IF !== (32'h00400020 ^ KEY)) begin n_errors++; $display("FAIL rw_instr got %h exp %h", Instr1_IF, 32'h00400020 ^ KEY); end
            n_checks++; if (mem_req_cnt - base !== 2) begin n_errors++; $display("FAIL rw_req_count got %0d exp 2", mem_req_cnt - base); end
        end
    endtask

    task automatic test_redirect_coincide();
        int base;
        do_reset();
        base = mem_req_cnt;
        @(negedge CLK);
        @(negedge CLK);
        STALL = 1'b1;
        @(negedge CLK);
        Request_Alt_PC = 1'b1; Alt_PC = 32'h00800000;
        @(negedge CLK);
        Request_Alt_PC = 1'b0; STALL = 1'b0;
        n_checks++; if (Instr_Valid_IF !== 1'b0) begin n_errors++; $display("FAIL rc_drop got %b exp 0", Instr_Valid_IF); end
        n_checks++; if (Instr_req_2IM !== 1'b1 || Instr_addr_2IM !== 32'h00800000) begin n_errors++; $display("FAIL rc_reissue got %b/%h exp 1/00800000", Instr_req_2IM, Instr_addr_2IM); end
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== 32'h00800000 || Instr1_IF !== (32'h00800000 ^ KEY)) begin n_errors++; $display("FAIL rc_target got %b/%h/%h exp 1/00800000/%h", Instr_Valid_IF, Instr_PC_IF, Instr1_IF, 32'h00800000 ^ KEY); end
        n_checks++; if (mem_req_cnt - base !== 3) begin n_errors++; $display("FAIL rc_req_count got %0d exp 3", mem_req_cnt - base); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        @(negedge CLK);
        @(negedge CLK);
        STALL = 1'b1;
        repeat (3) @(negedge CLK);
        n_checks++; if (Instr_req_2IM !== 1'b0 || Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== RST_PC) begin n_errors++; $display("FAIL rh_pre got %b/%b/%h exp 0/1/%h", Instr_req_2IM, Instr_Valid_IF, Instr_PC_IF, RST_PC); end
        Request_Alt_PC = 1'b1; Alt_PC = 32'h00C00040;
        @(negedge CLK);
        Request_Alt_PC = 1'b0;
        n_checks++; if (Instr_Valid_IF !== 1'b0 || Instr_req_2IM !== 1'b1 || Instr_addr_2IM !== 32'h00C00040) begin n_errors++; $display("FAIL rh_redirect got %b/%b/%h exp 0/1/00C00040", Instr_Valid_IF, Instr_req_2IM, Instr_addr_2IM); end
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== 32'h00C00040 || Instr_PC_Plus4_IF !== 32'h00C00044) begin n_errors++; $display("FAIL rh_target got %b/%h/%h exp 1/00C00040/00C00044", Instr_Valid_IF, Instr_PC_IF, Instr_PC_Plus4_IF); end
        @(negedge CLK);
        @(negedge CLK);
        STALL = 1'b0;
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== 32'h00C00044 || Instr1_IF !== (32'h00C00044 ^ KEY)) begin n_errors++; $display("FAIL rh_skid_next got %b/%h/%h exp 1/00C00044/%h", Instr_Valid_IF, Instr_PC_IF, Instr1_IF, 32'h00C00044 ^ KEY); end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        @(negedge CLK);
        Request_Alt_PC = 1'b1; Alt_PC = 32'hFFFFFFFC;
        @(negedge CLK);
        Request_Alt_PC = 1'b0;
        n_checks++; if (Instr_req_2IM !== 1'b1 || Instr_addr_2IM !== 32'hFFFFFFFC) begin n_errors++; $display("FAIL wrap_req got %b/%h exp 1/FFFFFFFC", Instr_req_2IM, Instr_addr_2IM); end
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== 32'hFFFFFFFC || Instr_PC_Plus4_IF !== 32'd0) begin n_errors++; $display("FAIL wrap_present got %b/%h/%h exp 1/FFFFFFFC/0", Instr_Valid_IF, Instr_PC_IF, Instr_PC_Plus4_IF); end
        n_checks++; if (Instr_req_2IM !== 1'b1 || Instr_addr_2IM !== 32'd0) begin n_errors++; $display("FAIL wrap_next got %b/%h exp 1/0", Instr_req_2IM, Instr_addr_2IM); end
        mem_lat = 4;
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        n_checks++; if (Instr_Valid_IF !== 1'b0 || Instr1_IF !== 32'd0 || Instr_PC_IF !== 32'd0 || Instr_PC_Plus4_IF !== 32'd0) begin n_errors++; $display("FAIL midrst_clear got %b/%h/%h/%h exp 0/0/0/0", Instr_Valid_IF, Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF); end
        n_checks++; if (Instr_addr_2IM !== RST_PC) begin n_errors++; $display("FAIL midrst_pc got %h exp %h", Instr_addr_2IM, RST_PC); end
        @(negedge CLK);
        @(negedge CLK);
        mem_lat = 1;
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++; if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== RST_PC || Instr1_IF !== (RST_PC ^ KEY)) begin n_errors++; $display("FAIL midrst_restart got %b/%h/%h exp 1/%h/%h", Instr_Valid_IF, Instr_PC_IF, Instr1_IF, RST_PC, RST_PC ^ KEY); end
    endtask

    // Reference: consumed instructions form the sequence PC, PC+4, ... from
    // the last redirect target (or reset PC), each word equal to its PC^KEY.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          consumed;
        logic        p_valid, p_stall, p_redir;
        logic [31:0] p_pc, p_instr, p_plus4, p_alt;
        do_reset();
        mem_rand_lat = 1'b1;
        exp_pc = RST_PC; consumed = 0;
        p_valid = 1'b0; p_stall = 1'b0; p_redir = 1'b0;
        p_pc = 32'd0; p_instr = 32'd0; p_plus4 = 32'd0; p_alt = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge CLK);
            if (p_valid && !p_stall) begin
                n_checks++;
                if (p_pc !== exp_pc || p_instr !== (exp_pc ^ KEY) || p_plus4 !== exp_pc + 32'd4) begin
                    n_errors++;
                    $display("FAIL rand_consume@%0d got %h/%h/%h exp %h/%h/%h", cyc, p_pc, p_instr, p_plus4, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4);
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (p_redir) begin
                exp_pc = p_alt;
                n_checks++; if (Instr_Valid_IF !== 1'b0) begin n_errors++; $display("FAIL rand_redirect_drop@%0d got %b exp 0", cyc, Instr_Valid_IF); end
            end else if (p_valid && p_stall) begin
                n_checks++;
                if (Instr_Valid_IF !== 1'b1 || Instr_PC_IF !== p_pc || Instr1_IF !== p_instr) begin
                    n_errors++;
                    $display("FAIL rand_stall_hold@%0d got %b/%h exp 1/%h", cyc, Instr_Valid_IF, Instr_PC_IF, p_pc);
                end
            end
            p_valid = Instr_Valid_IF; p_pc = Instr_PC_IF; p_instr = Instr1_IF; p_plus4 = Instr_PC_Plus4_IF;
            STALL          = ($urandom_range(0, 9) < 3);
            Request_Alt_PC = ($urandom_range(0, 39) == 0);
            Alt_PC         = $urandom;
            p_stall = STALL; p_redir = Request_Alt_PC; p_alt = Alt_PC;
        end
        @(negedge CLK);
        STALL = 1'b0; Request_Alt_PC = 1'b0; mem_rand_lat = 1'b0;
        n_checks++; if (consumed < 150) begin n_errors++; $display("FAIL rand_progress got %0d exp >=150", consumed); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_skid();
        test_redirect_wait();
        test_redirect_coincide();
        test_redirect_hold();
        test_wrap_and_reset();
        test_random();
        repeat (4) @(negedge CLK);
        n_checks++; if (proto_viol !== 0) begin n_errors++; $display("FAIL protocol got %0d overlapping requests exp 0", proto_viol); end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
